// File: rtl/pe_pkg.sv
// Shared defaults, FSM state encoding and lane slicing constants for the PE multiply stage.
// Imported by pe_mult_pipe and pe_mult_lane.
package pe_pkg;

    localparam int DEF_LANES = 32;
    localparam int DEF_DW    = 16;
    localparam int DEF_PW    = 32;
    localparam int DEF_CNTW  = 8;

    // Flattened bus widths for the default lane geometry
    localparam int DEF_IN_W  = DEF_LANES * DEF_DW;
    localparam int DEF_OUT_W = DEF_LANES * DEF_PW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pe_mult_lane.sv
// One combinational signed DW x DW -> PW multiplier lane.
// Zero latency; no handshake, purely combinational.
module pe_mult_lane #(
    parameter int DW = 16,
    parameter int PW = 32
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [PW-1:0] p
);

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;

    // Sign-extend to full product width so the multiply is done at PW bits
    assign a_ext = {{(PW-DW){a[DW-1]}}, a};
    assign b_ext = {{(PW-DW){b[DW-1]}}, b};
    assign p     = a_ext * b_ext;

endmodule

// File: rtl/pe_mult_pipe.sv
// Producer stage for the PE adder tree: 32-lane signed multiply, 1-cycle registered output, job-bounded by beat count.
// Valid/ready backpressure; output register holds while stalled. Optional stall counter under PE_MULT_STAT_EN.
module pe_mult_pipe
    import pe_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int DW    = DEF_DW,
    parameter int PW    = DEF_PW,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CNTW-1:0]     beat_num,
    input  logic [LANES*DW-1:0] neuron,
    input  logic [LANES*DW-1:0] weight,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [LANES*PW-1:0] mult_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                done,
    output logic                busy
`ifdef PE_MULT_STAT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    state_t              state;
    state_t              state_nxt;
    logic [CNTW-1:0]     remain;
    logic [LANES*PW-1:0] prod;
    logic                start_ok;
    logic                in_fire;
    logic                out_fire;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        pe_mult_lane #(
            .DW (DW),
            .PW (PW)
        ) u_lane (
            .a (neuron[j*DW +: DW]),
            .b (weight[j*DW +: DW]),
            .p (prod[j*PW +: PW])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        start_ok  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && (beat_num != '0)) begin
                    start_ok  = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready = (remain != '0) && (!out_valid || out_ready);
                if (in_valid && in_ready && (remain == CNTW'(1))) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_valid && out_ready && out_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign done     = (state == ST_DRAIN) && out_fire && out_last;
    assign busy     = (state != ST_IDLE);

    // A simultaneous input fire wins over output fire: reload keeps out_valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain      <= '0;
            mult_result <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            if (start_ok) begin
                remain <= beat_num;
            end else if (in_fire) begin
                remain <= remain - CNTW'(1);
            end

            if (in_fire) begin
                mult_result <= prod;
                out_valid   <= 1'b1;
                out_last    <= (remain == CNTW'(1));
            end else if (out_fire) begin
                out_valid   <= 1'b0;
                out_last    <= 1'b0;
            end
        end
    end

`ifdef PE_MULT_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
        end else if (start_ok) begin
            stall_cnt <= 16'd0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_mult_pipe.sv
// Directed self-checking bench for pe_mult_pipe; define PE_MULT_STAT_EN to also cover the stall counter.
module tb_pe_mult_pipe;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [7:0]    beat_num;
    logic [511:0]  neuron;
    logic [511:0]  weight;
    logic          in_valid;
    logic          in_ready;
    logic [1023:0] mult_result;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          done;
    logic          busy;
`ifdef PE_MULT_STAT_EN
    logic [15:0]   stall_cnt;
`endif

    int checks;
    int errors;

    pe_mult_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .beat_num    (beat_num),
        .neuron      (neuron),
        .weight      (weight),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mult_result (mult_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .done        (done),
        .busy        (busy)
`ifdef PE_MULT_STAT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] n, input logic [15:0] w);
        for (int j = 0; j < 32; j++) begin
            neuron[j*16 +: 16] = n;
            weight[j*16 +: 16] = w;
        end
    endtask

    function automatic logic [31:0] lane(input int j);
        return mult_result[j*32 +: 32];
    endfunction

    function automatic bit all_lanes(input logic [31:0] v);
        for (int j = 0; j < 32; j++) begin
            if (lane(j) !== v) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic kick(input logic [7:0] n);
        start = 1'b1;
        beat_num = n;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b exp 0", out_last); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (mult_result !== '0) begin errors++; $display("FAIL rst_mult_result got %h exp 0", lane(0)); end
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        kick(8'd1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b exp 1", in_ready); end
        fill(16'd3, 16'hFFFE);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL single_out_last got %b exp 1", out_last); end
        checks++; if (!all_lanes(32'hFFFF_FFFA)) begin errors++; $display("FAIL single_lanes got %h exp fffffffa", lane(0)); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done got %b exp 1", done); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_in_ready_drain got %b exp 0", in_ready); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_end got %b exp 0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_out_valid_end got %b exp 0", out_valid); end
    endtask

    task automatic test_extremes();
        out_ready = 1'b1;
        kick(8'd1);
        fill(16'd0, 16'd0);
        neuron[15:0]    = 16'h8000;
        weight[15:0]    = 16'h8000;
        neuron[511:496] = 16'h7FFF;
        weight[511:496] = 16'h8000;
        neuron[95:80]   = 16'h7FFF;
        weight[95:80]   = 16'h7FFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (lane(0) !== 32'h4000_0000) begin errors++; $display("FAIL ext_lane0 got %h exp 40000000", lane(0)); end
        checks++; if (lane(31) !== 32'hC000_8000) begin errors++; $display("FAIL ext_lane31 got %h exp c0008000", lane(31)); end
        checks++; if (lane(5) !== 32'h3FFF_0001) begin errors++; $display("FAIL ext_lane5 got %h exp 3fff0001", lane(5)); end
        checks++; if (lane(7) !== 32'h0) begin errors++; $display("FAIL ext_lane7 got %h exp 0", lane(7)); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_v;
        out_ready = 1'b1;
        kick(8'd4);
        for (int k = 0; k < 4; k++) begin
            fill(16'(k + 1), 16'd10);
            in_valid = 1'b1;
            step();
            exp_v = 32'((k + 1) * 10);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid beat %0d got %b exp 1", k, out_valid); end
            checks++; if (!all_lanes(exp_v)) begin errors++; $display("FAIL b2b_data beat %0d got %h exp %h", k, lane(0), exp_v); end
            checks++; if (out_last !== (k == 3)) begin errors++; $display("FAIL b2b_last beat %0d got %b exp %b", k, out_last, k == 3); end
            checks++; if (done !== (k == 3)) begin errors++; $display("FAIL b2b_done beat %0d got %b exp %b", k, done, k == 3); end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_after got %b exp 0", in_ready); end
        in_valid = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b exp 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_end got %b exp 0", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        kick(8'd3);
        fill(16'd1, 16'hFFFF);
        in_valid = 1'b1;
        step();
        checks++; if (lane(0) !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stall_beat0 got %h exp ffffffff", lane(0)); end
        out_ready = 1'b0;
        fill(16'd2, 16'hFFFF);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b exp 0", in_ready); end
        for (int c = 0; c < 2; c++) begin
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid cyc %0d got %b exp 1", c, out_valid); end
            checks++; if (!all_lanes(32'hFFFF_FFFF)) begin errors++; $display("FAIL stall_hold_data cyc %0d got %h exp ffffffff", c, lane(0)); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_hold_in_ready cyc %0d got %b exp 0", c, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_in_ready got %b exp 1", in_ready); end
        step();
        checks++; if (!all_lanes(32'hFFFF_FFFE)) begin errors++; $display("FAIL stall_beat1 got %h exp fffffffe", lane(0)); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL stall_beat1_last got %b exp 0", out_last); end
        fill(16'd3, 16'hFFFF);
        step();
        in_valid = 1'b0;
        checks++; if (!all_lanes(32'hFFFF_FFFD)) begin errors++; $display("FAIL stall_beat2 got %h exp fffffffd", lane(0)); end
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL stall_beat2_last got %b exp 1", out_last); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done got %b exp 1", done); end
`ifdef PE_MULT_STAT_EN
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL stall_cnt got %0d exp 2", stall_cnt); end
`endif
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_ignore();
        out_ready = 1'b1;
        kick(8'd0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL zero_in_ready got %b exp 0", in_ready); end
        fill(16'd7, 16'd7);
        in_valid = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_in_valid got %b exp 0", out_valid); end
        in_valid = 1'b0;
        kick(8'd2);
        start = 1'b1;
        beat_num = 8'd5;
        fill(16'd2, 16'd2);
        in_valid = 1'b1;
        step();
        start = 1'b0;
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL run_start_beat1_last got %b exp 0", out_last); end
        checks++; if (lane(3) !== 32'd4) begin errors++; $display("FAIL run_start_beat1 got %h exp 4", lane(3)); end
        fill(16'd5, 16'hFFFD);
        step();
        in_valid = 1'b0;
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL run_start_beat2_last got %b exp 1", out_last); end
        checks++; if (lane(3) !== 32'hFFFF_FFF1) begin errors++; $display("FAIL run_start_beat2 got %h exp fffffff1", lane(3)); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL run_start_done got %b exp 1", done); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_start_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        kick(8'd4);
        fill(16'd9, 16'd9);
        in_valid = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
        checks++; if (mult_result !== '0) begin errors++; $display("FAIL mid_rst_data got %h exp 0", lane(0)); end
        step();
        rst_n = 1'b1;
        step();
        kick(8'd2);
        fill(16'd4, 16'd4);
        in_valid = 1'b1;
        step();
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL post_rst_beat1_last got %b exp 0", out_last); end
        fill(16'd6, 16'd4);
        step();
        in_valid = 1'b0;
        checks++; if (!all_lanes(32'd24)) begin errors++; $display("FAIL post_rst_beat2 got %h exp 18", lane(0)); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL post_rst_done got %b exp 1", done); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy_end got %b exp 0", busy); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        beat_num  = 8'd0;
        neuron    = '0;
        weight    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_extremes();
        test_back_to_back();
        test_stall();
        test_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
